// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte over valid/ready and sends it as
// start + 8 data bits (LSB first) + optional parity + 1 or 2 stop bits.
module uart_tx #(
    parameter int CLOCKS_PER_BIT = 1302,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_ready,
    output logic       o_tx_bit,
    output logic       o_tx_active,
    output logic       o_tx_done
);

    localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_MAX = 3'(STOP_BITS - 1);

    generate
        if (CLOCKS_PER_BIT < 2) begin : g_bad_cpb
            $error("uart_tx: CLOCKS_PER_BIT must be >= 2");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       idx_reg;
    logic [7:0]       shift_reg;
    logic             parity_reg;

    wire bit_end = (cnt_reg == CNT_MAX);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            o_tx_bit    <= 1'b1;
            o_tx_ready  <= 1'b1;
            o_tx_active <= 1'b0;
            o_tx_done   <= 1'b0;
        end else begin
            o_tx_done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (i_tx_valid) begin
                        shift_reg   <= i_tx_byte;
                        // odd parity inverts the XOR so data+parity holds an odd count of 1s
                        parity_reg  <= (PARITY == 1) ? ~(^i_tx_byte) : ^i_tx_byte;
                        cnt_reg     <= '0;
                        state_reg   <= S_START;
                        o_tx_bit    <= 1'b0;
                        o_tx_ready  <= 1'b0;
                        o_tx_active <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cnt_reg   <= '0;
                        idx_reg   <= '0;
                        state_reg <= S_DATA;
                        o_tx_bit  <= shift_reg[0];
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt_reg <= '0;
                        if (idx_reg == 3'd7) begin
                            idx_reg <= '0;
                            if (PARITY != 0) begin
                                state_reg <= S_PARITY;
                                o_tx_bit  <= parity_reg;
                            end else begin
                                state_reg <= S_STOP;
                                o_tx_bit  <= 1'b1;
                            end
                        end else begin
                            // shift keeps the next data bit at position 1
                            idx_reg   <= idx_reg + 1'b1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            o_tx_bit  <= shift_reg[1];
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        cnt_reg   <= '0;
                        idx_reg   <= '0;
                        state_reg <= S_STOP;
                        o_tx_bit  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        cnt_reg <= '0;
                        if (idx_reg == STOP_MAX) begin
                            idx_reg     <= '0;
                            state_reg   <= S_IDLE;
                            o_tx_ready  <= 1'b1;
                            o_tx_active <= 1'b0;
                            o_tx_done   <= 1'b1;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg   <= S_IDLE;
                    cnt_reg     <= '0;
                    idx_reg     <= '0;
                    o_tx_bit    <= 1'b1;
                    o_tx_ready  <= 1'b1;
                    o_tx_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter; the upstream stage that drives the line consumed by uart_rx.
- Accepts a byte over a valid/ready handshake and serialises it as a frame: 1 start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Bit timing is set by a clock-per-bit count matching uart_rx (default 1302 clocks per bit).

Parameters:
- CLOCKS_PER_BIT, 1302, i_clk cycles per serial bit; legal range >= 2.
- PARITY, 0, 0 = none, 1 = odd, 2 = even; any other value is an elaboration error.
- STOP_BITS, 1, number of stop bits; 1 or 2, any other value is an elaboration error.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst  input  1  reset; asynchronous, active-high.
- i_tx_valid  input  1  i_tx_byte holds a byte to send.
- i_tx_byte  input  8  byte to transmit; sampled only on the accept edge.
- o_tx_ready  output  1  block can accept a byte this cycle.
- o_tx_bit  output  1  serial line; idle high.
- o_tx_active  output  1  high while a frame is on the line.
- o_tx_done  output  1  one-cycle pulse when a frame's last stop bit completes.

Behaviour:
- Reset, asynchronous:
  - o_tx_bit=1, o_tx_ready=1, o_tx_active=0, o_tx_done=0.
  - State=IDLE; bit-time counter, bit index and shift register cleared.
  - Reset mid-frame abandons the frame and forces the line high immediately; no o_tx_done is produced.
- Accept: a byte is accepted on a rising edge where i_tx_valid=1 and o_tx_ready=1. i_tx_byte is latched into the shift register and parity is computed from the latched byte.
  - Odd parity: the parity bit makes the total count of 1s across data+parity odd.
  - Even parity: that total count is even.
- When i_tx_valid=1 and o_tx_ready=0, the input is ignored. There is no queueing; the upstream block holds valid.
- State machine, one state per bit field. Each state holds o_tx_bit for exactly CLOCKS_PER_BIT cycles, counted 0..CLOCKS_PER_BIT-1. The counter width is clog2(CLOCKS_PER_BIT).
  - IDLE: o_tx_bit=1, o_tx_ready=1, o_tx_active=0. On accept -> START.
  - START: o_tx_bit=0. On count expiry -> DATA with bit index 0.
  - DATA: o_tx_bit=shift[index]. On expiry, index increments. After index 7: -> PARITY if PARITY!=0, else -> STOP.
  - PARITY: o_tx_bit=parity bit. On expiry -> STOP.
  - STOP: o_tx_bit=1 for STOP_BITS*CLOCKS_PER_BIT cycles. On expiry -> IDLE and o_tx_done=1 for that single cycle.
- Output registration: all outputs are registered.
  - o_tx_bit changes exactly on bit boundaries, with no glitches.
  - o_tx_ready=0 and o_tx_active=1 from the cycle after accept until the return to IDLE.
- Latency: the start bit appears on o_tx_bit 1 cycle after the accept edge.
- Frame length from the first start-bit cycle to the return to IDLE: (1+8+P+STOP_BITS)*CLOCKS_PER_BIT cycles, where P is 1 if parity is enabled, else 0.
- Back-to-back: if i_tx_valid is held high, the next byte is accepted on the first IDLE cycle. This gives exactly 1 extra idle-high cycle between frames beyond the stop bits.
- The data byte is held internally. Changing i_tx_byte during a frame has no effect.

Test Plan:
- Reset idle: assert i_rst for 5 cycles, then release -> o_tx_bit=1, o_tx_ready=1, o_tx_active=0, o_tx_done=0. Asserting i_rst mid-data-bit forces o_tx_bit=1 asynchronously, and no o_tx_done follows.
- Single frame, CLOCKS_PER_BIT=4, PARITY=0, STOP_BITS=1:
  - Stimulus: send 0x3F.
  - Line sequence, each bit 4 cycles: 0,1,1,1,1,1,1,0,0,1.
  - o_tx_done pulses once, 40 cycles after the start bit begins.
  - o_tx_ready stays low for those 40 cycles.
- Parity:
  - PARITY=1 (odd), send 0x3F: parity bit=1.
  - PARITY=2 (even), send 0x3F: parity bit=0.
  - PARITY=2, send 0x00: parity bit=0; frame is 11 bits.
- Two stop bits: STOP_BITS=2, CLOCKS_PER_BIT=4, send 0xA5 -> stop high for 8 cycles; frame is 44 cycles.
- Back-to-back: hold i_tx_valid with 0x55 then 0xAA -> the second start bit begins exactly 1 cycle after the first o_tx_done. Changing i_tx_byte mid-frame does not alter the bits already committed for the current frame.
- Loopback: defaults with a 20 ns clock, o_tx_bit wired to uart_rx (CLOCKS_PER_BIT=1302), send 0x3F -> uart_rx o_rx_byte=0x3F with o_rx_data_valid pulsed. Frame duration is 260.4 us.
